vec_mem_stage: RTL
==================

Name: vec_mem_stage

Overview:
- Memory-stage access sequencer for the 16-lane x 32-bit vector pipeline.
- Sits between the EX/MEM and MEM/WB pipeline registers and produces the per-lane read data that the MEM/WB register captures.
- Serializes one vector load or store into LANES single-word transactions on a narrow data-memory port.
- Stalls the pipeline until all lanes complete.

Parameters:
- LANES, 16, number of vector lanes; must be a power of two.
- DW, 32, lane data width in bits.
- AW, 32, byte-address width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-low.
- MemReadM  in  1  vector load present in the MEM stage.
- MemWriteM  in  1  vector store present in the MEM stage.
- BaseAddrM  in  AW  byte address of lane 0.
- WriteDataM  in  LANES x DW  store data; lane i is written to BaseAddrM+4i.
- ReadDataM  out  LANES x DW  load result, consumed by the MEM/WB register.
- StallM  out  1  freezes the PC and all pipeline registers up to and including EX/MEM.
- mem_req  out  1  single-word request valid.
- mem_we  out  1  1 = write, 0 = read; valid only while mem_req=1.
- mem_addr  out  AW  request byte address.
- mem_wdata  out  DW  request write data.
- mem_gnt  in  1  memory accepts the request in this cycle (mem_req & mem_gnt).
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DW  read data.

Behaviour:
- Reset (RST=0 at a rising edge):
  - State to IDLE; lane counter to 0; ReadDataM to all zeros; the latched write flag to 0.
  - While RST=0: StallM=0 and mem_req=0.
- State IDLE:
  - If MemWriteM or MemReadM is 1: StallM=1 combinationally in the same cycle, the op type is latched (write has priority if both are set), lane is set to 0, next state is REQ.
  - Otherwise StallM=0.
- State REQ:
  - Outputs: mem_req=1, mem_we equals the latched op, mem_addr=BaseAddrM+(lane<<2) modulo 2^AW, mem_wdata=WriteDataM[lane]. StallM=1.
  - BaseAddrM and WriteDataM are stable because EX/MEM is frozen.
  - mem_gnt=0: hold all request outputs.
  - Write and mem_gnt=1: if lane==LANES-1, go to DONE; otherwise lane+1 and stay in REQ (back-to-back requests allowed).
  - Read and mem_gnt=1: go to WAIT.
- State WAIT (reads only):
  - mem_req=0; StallM=1.
  - On mem_rvalid: ReadDataM[lane] <= mem_rdata. If lane==LANES-1, go to DONE; otherwise lane+1 and return to REQ.
- State DONE:
  - One cycle with StallM=0 and mem_req=0.
  - Upstream registers advance and MEM/WB captures ReadDataM at the closing edge.
  - Unconditional transition to IDLE; the new MEM-stage instruction is evaluated in IDLE.
- ReadDataM is held between loads. A store leaves it unchanged. Lanes are updated individually as read data returns.
- mem_rvalid is ignored in IDLE, REQ and DONE, so a stale response after reset is dropped.
- The lane counter is log2(LANES) bits wide and never wraps inside an operation.
- Address arithmetic wraps modulo 2^AW without a flag.
- Reset mid-operation: the operation is abandoned and the outstanding request is dropped. Memory-side effects of lanes already granted are not undone.
- Latency with mem_gnt tied to 1:
  - Store: StallM high for LANES+1 cycles; DONE follows.
  - Load with rvalid one cycle after gnt: StallM high for 2*LANES+1 cycles.

Test Plan:
- Reset: RST=0 for 2 cycles with MemReadM=1 -> StallM=0, mem_req=0, ReadDataM=0. Release -> StallM=1 in the same cycle.
- Store, mem_gnt=1, BaseAddrM=0x100, WriteDataM[i]=i+0xA0 -> 16 consecutive writes to addresses 0x100..0x13C with data 0xA0..0xAF; StallM high for 17 cycles, then a 1-cycle DONE with StallM=0.
- Load, memory model returns rvalid 1 cycle after gnt with data=addr^0xFFFF, BaseAddrM=0x200 -> ReadDataM[i]=(0x200+4i)^0xFFFF; StallM high for 33 cycles.
- Grant backpressure: mem_gnt=0 for 3 cycles on lane 5 of a store -> mem_addr and mem_wdata held constant; total stall 20 cycles.
- MemReadM=MemWriteM=1 -> store sequence only; ReadDataM unchanged. Wrap case: BaseAddrM=0xFFFFFFF8 -> lane 2 address is 0x00000000.
- Abort: RST=0 during WAIT at lane 7, then a spurious mem_rvalid -> state IDLE, ReadDataM=0, no lane updated.

Source files
------------

// File: rtl/vec_mem_stage_if.sv
// rtl/vec_mem_stage_if.sv - narrow single-word data-memory port
interface vec_mem_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vec_mem_stage.sv
// rtl/vec_mem_stage.sv - vector MEM-stage sequencer, one lane word per memory transaction
module vec_mem_stage #(
  parameter int LANES = 16,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       MemReadM,
  input  logic                       MemWriteM,
  input  logic [AW-1:0]              BaseAddrM,
  input  logic [LANES-1:0][DW-1:0]   WriteDataM,
  output logic [LANES-1:0][DW-1:0]   ReadDataM,
  output logic                       StallM,
  vec_mem_stage_if.master            mem
);
  localparam int            LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic                       we_q, we_d;
  logic [LANES-1:0][DW-1:0]   rdata_q, rdata_d;
  logic                       last_lane;
  logic                       op_req;

  assign last_lane = (lane_q == LAST);
  assign op_req    = MemWriteM | MemReadM;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (op_req) begin
          we_d    = MemWriteM;
          lane_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          if (!we_q) begin
            state_d = WAIT;
          end else if (last_lane) begin
            state_d = DONE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d[lane_q] = mem.mem_rdata;
          if (last_lane) begin
            state_d = DONE;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      lane_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall rises in the IDLE cycle that sees the op so EX/MEM never advances past it
  always_comb begin
    StallM = 1'b0;
    if (RST) begin
      case (state_q)
        IDLE:    StallM = op_req;
        REQ:     StallM = 1'b1;
        WAIT:    StallM = 1'b1;
        default: StallM = 1'b0;
      endcase
    end
  end

  assign mem.mem_req   = RST && (state_q == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = BaseAddrM + AW'({lane_q, 2'b00});
  assign mem.mem_wdata = WriteDataM[lane_q];
  assign ReadDataM     = rdata_q;
endmodule
